// File: rtl/ysyx_lsu_pkg.sv
// rtl/ysyx_lsu_pkg.sv - size encodings, FSM states and lane helpers for the LSU bridge
// Shared by ysyx_lsu_bridge and ysyx_lsu_lane.
package ysyx_lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT0 = 2'd1,
    S_BEAT1 = 2'd2,
    S_RESP  = 2'd3
  } lsu_state_e;

  // Size 3 is illegal on the core side and is handled as a word.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'd3) ? SZ_W : size;
  endfunction

  function automatic logic [3:0] lanes(input logic [1:0] size);
    case (size)
      SZ_B:    return 4'b0001;
      SZ_H:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic is_cross(input logic [1:0] size, input logic [1:0] off);
    return ((size == SZ_H) && (off == 2'd3)) || ((size == SZ_W) && (off != 2'd0));
  endfunction

endpackage

// File: rtl/ysyx_lsu_lane.sv
// rtl/ysyx_lsu_lane.sv - store lane shift/mask generation and load extract/extend
// Beat-0 and beat-1 views come from one 64-bit shift of the operand.
module ysyx_lsu_lane
  import ysyx_lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [63:0] rdata,
  output logic [3:0]  mask0,
  output logic [3:0]  mask1,
  output logic [31:0] wdata0,
  output logic [31:0] wdata1,
  output logic [31:0] load_data
);

  logic [7:0]  mask_w;
  logic [63:0] wdata_w;
  logic [31:0] rdata_sh;

  always_comb begin
    mask_w   = {4'b0000, lanes(size)} << off;
    wdata_w  = {32'd0, wdata} << {off, 3'b000};
    rdata_sh = 32'(rdata >> {off, 3'b000});
    case (size)
      SZ_B:    load_data = {{24{~is_unsigned & rdata_sh[7]}}, rdata_sh[7:0]};
      SZ_H:    load_data = {{16{~is_unsigned & rdata_sh[15]}}, rdata_sh[15:0]};
      default: load_data = rdata_sh;
    endcase
  end

  assign mask0  = mask_w[3:0];
  assign mask1  = mask_w[7:4];
  assign wdata0 = wdata_w[31:0];
  assign wdata1 = wdata_w[63:32];

endmodule

// File: rtl/ysyx_lsu_bridge.sv
// rtl/ysyx_lsu_bridge.sv - core load/store port to single-beat LSU bus bridge
// Define LSU_SPLIT_MISALIGNED_EN to split word-crossing accesses into two beats.
module ysyx_lsu_bridge
  import ysyx_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_wen,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] io_lsu_addr,
  output logic              io_lsu_reqValid,
  output logic [1:0]        io_lsu_size,
  output logic              io_lsu_wen,
  output logic [DATA_W-1:0] io_lsu_wdata,
  output logic [3:0]        io_lsu_wmask,
  input  logic [DATA_W-1:0] io_lsu_rdata,
  input  logic              io_lsu_respValid
);

  if (DATA_W != 32) begin : g_bad_data_w
    $error("ysyx_lsu_bridge supports only DATA_W == 32");
  end

`ifdef LSU_SPLIT_MISALIGNED_EN
  localparam logic SPLIT_EN = 1'b1;
`else
  localparam logic SPLIT_EN = 1'b0;
`endif

  lsu_state_e        state;
  logic [ADDR_W-1:0] addr_q;
  logic              wen_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata0_q;
  logic              cross_q;

  logic              idle;
  logic [1:0]        req_sz;
  logic              req_cross;
  logic [1:0]        cur_size;
  logic [1:0]        cur_off;
  logic [31:0]       cur_wdata;
  logic [63:0]       rdata_pair;
  logic [3:0]        mask0, mask1;
  logic [31:0]       wdata0, wdata1, load_data;

  assign idle      = (state == S_IDLE);
  assign req_sz    = norm_size(req_size);
  assign req_cross = is_cross(req_sz, req_addr[1:0]);

  // Lane logic sees the live request while idle so beat 0 can be registered on accept.
  assign cur_size   = idle ? req_sz : size_q;
  assign cur_off    = idle ? req_addr[1:0] : addr_q[1:0];
  assign cur_wdata  = idle ? req_wdata : wdata_q;
  assign rdata_pair = (state == S_BEAT1) ? {io_lsu_rdata, rdata0_q} : {32'd0, io_lsu_rdata};

  ysyx_lsu_lane u_lane (
    .size        (cur_size),
    .off         (cur_off),
    .is_unsigned (uns_q),
    .wdata       (cur_wdata),
    .rdata       (rdata_pair),
    .mask0       (mask0),
    .mask1       (mask1),
    .wdata0      (wdata0),
    .wdata1      (wdata1),
    .load_data   (load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      req_ready       <= 1'b1;
      rsp_valid       <= 1'b0;
      rsp_rdata       <= '0;
      rsp_err         <= 1'b0;
      io_lsu_addr     <= '0;
      io_lsu_reqValid <= 1'b0;
      io_lsu_size     <= '0;
      io_lsu_wen      <= 1'b0;
      io_lsu_wdata    <= '0;
      io_lsu_wmask    <= '0;
      addr_q          <= '0;
      wen_q           <= 1'b0;
      size_q          <= '0;
      uns_q           <= 1'b0;
      wdata_q         <= '0;
      rdata0_q        <= '0;
      cross_q         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          addr_q    <= req_addr;
          wen_q     <= req_wen;
          size_q    <= req_sz;
          uns_q     <= req_unsigned;
          wdata_q   <= req_wdata;
          cross_q   <= req_cross;
          req_ready <= 1'b0;
          if (!req_cross || SPLIT_EN) begin
            state           <= S_BEAT0;
            io_lsu_reqValid <= 1'b1;
            io_lsu_addr     <= req_cross ? {req_addr[ADDR_W-1:2], 2'b00} : req_addr;
            io_lsu_size     <= req_cross ? SZ_W : req_sz;
            io_lsu_wen      <= req_wen;
            io_lsu_wmask    <= mask0;
            io_lsu_wdata    <= wdata0;
          end else begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end
        end
        S_BEAT0: if (io_lsu_respValid) begin
          if (cross_q) begin
            state        <= S_BEAT1;
            rdata0_q     <= io_lsu_rdata;
            io_lsu_addr  <= {addr_q[ADDR_W-1:2], 2'b00} + ADDR_W'(4);
            io_lsu_wmask <= mask1;
            io_lsu_wdata <= wdata1;
          end else begin
            state           <= S_RESP;
            io_lsu_reqValid <= 1'b0;
            rsp_valid       <= 1'b1;
            rsp_err         <= 1'b0;
            rsp_rdata       <= wen_q ? '0 : load_data;
          end
        end
        S_BEAT1: if (io_lsu_respValid) begin
          state           <= S_RESP;
          io_lsu_reqValid <= 1'b0;
          rsp_valid       <= 1'b1;
          rsp_err         <= 1'b0;
          rsp_rdata       <= wen_q ? '0 : load_data;
        end
        default: begin
          state     <= S_IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_lsu_bridge.sv
// tb/tb_ysyx_lsu_bridge.sv - self-checking bench for ysyx_lsu_bridge (table, random and reset sequences)
module tb_ysyx_lsu_bridge;

`ifdef LSU_SPLIT_MISALIGNED_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic [31:0] req_addr = '0;
  logic        req_wen = 1'b0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] io_lsu_addr, io_lsu_wdata;
  logic        io_lsu_reqValid, io_lsu_wen;
  logic [1:0]  io_lsu_size;
  logic [3:0]  io_lsu_wmask;
  logic [31:0] io_lsu_rdata = '0;
  logic        io_lsu_respValid = 1'b0;

  always #5 clk = ~clk;

  ysyx_lsu_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_wen(req_wen),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .io_lsu_addr(io_lsu_addr), .io_lsu_reqValid(io_lsu_reqValid), .io_lsu_size(io_lsu_size),
    .io_lsu_wen(io_lsu_wen), .io_lsu_wdata(io_lsu_wdata), .io_lsu_wmask(io_lsu_wmask),
    .io_lsu_rdata(io_lsu_rdata), .io_lsu_respValid(io_lsu_respValid)
  );

  typedef struct {
    logic [31:0] a; bit w; logic [1:0] sz; bit u; logic [31:0] wd;
    bit tbl; logic [31:0] rd0, rd1; int dly;
    int nb; logic [31:0] a0; logic [1:0] sz0; logic [3:0] m0, m1; logic [31:0] w0, w1;
    logic [31:0] rdata; bit err;
  } vec_t;

  int n_cmp = 0, n_fail = 0;

  int          obs_nb, obs_lat;
  bit          obs_got;
  logic [31:0] obs_addr[2], obs_wdata[2];
  logic [3:0]  obs_mask[2];
  logic [1:0]  obs_size[2];
  logic        obs_wen[2];
  logic [31:0] obs_rdata;
  logic        obs_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w * 32'h9E3779B1) ^ 32'h5A5A3C3C;
  endfunction

  function automatic logic [31:0] mskd(input logic [31:0] w, input logic [3:0] m);
    return w & {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  function automatic vec_t mk(input logic [31:0] a, input bit w, input logic [1:0] sz, input bit u,
                              input logic [31:0] wd, input logic [31:0] rd0, input logic [31:0] rd1,
                              input int dly, input int nb, input logic [31:0] a0, input logic [1:0] sz0,
                              input logic [3:0] m0, input logic [31:0] w0, input logic [3:0] m1,
                              input logic [31:0] w1, input logic [31:0] rdata, input bit err);
    vec_t v;
    v.a = a; v.w = w; v.sz = sz; v.u = u; v.wd = wd; v.tbl = 1'b1; v.rd0 = rd0; v.rd1 = rd1;
    v.dly = dly; v.nb = nb; v.a0 = a0; v.sz0 = sz0; v.m0 = m0; v.w0 = w0; v.m1 = m1; v.w1 = w1;
    v.rdata = rdata; v.err = err;
    return v;
  endfunction

  // Reference: walk the accessed bytes one at a time against a byte-addressed view of memory.
  function automatic vec_t model(input logic [31:0] a, input bit w, input logic [1:0] sz, input bit u,
                                 input logic [31:0] wd, input int dly);
    vec_t v;
    int n, wi;
    logic [31:0] ba, ld, word;
    logic [3:0] m[2];
    logic [31:0] wv[2];
    v = mk(a, w, sz, u, wd, 0, 0, dly, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v.tbl = 1'b0;
    n = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    m[0] = 0; m[1] = 0; wv[0] = 0; wv[1] = 0; ld = 0;
    for (int i = 0; i < n; i++) begin
      ba = a + i;
      wi = (ba[31:2] != a[31:2]) ? 1 : 0;
      m[wi][ba[1:0]] = 1'b1;
      wv[wi][8*ba[1:0] +: 8] = wd[8*i +: 8];
      word = mem_word(ba) >> (8 * ba[1:0]);
      ld[8*i +: 8] = word[7:0];
    end
    if (!u && n < 4 && ld[8*n-1]) ld = ld | (32'hFFFFFFFF << (8 * n));
    if (m[1] != 0 && !EN) begin
      v.err = 1'b1;
    end else begin
      v.nb = (m[1] != 0) ? 2 : 1;
      v.a0 = (m[1] != 0) ? {a[31:2], 2'b00} : a;
      v.sz0 = (m[1] != 0 || sz == 3) ? 2'd2 : sz;
      v.m0 = m[0]; v.m1 = m[1]; v.w0 = wv[0]; v.w1 = wv[1];
      v.rdata = w ? 32'd0 : ld;
    end
    return v;
  endfunction

  task automatic run_txn(input vec_t v);
    int wait_cnt;
    req_valid = 1'b1; req_addr = v.a; req_wen = v.w; req_size = v.sz;
    req_unsigned = v.u; req_wdata = v.wd;
    @(negedge clk);
    req_valid = 1'b0;
    obs_nb = 0; obs_got = 0; obs_lat = 0; wait_cnt = 0;
    for (int cyc = 1; cyc <= 40 && !obs_got; cyc++) begin
      if (rsp_valid) begin
        obs_got = 1; obs_lat = cyc; obs_rdata = rsp_rdata; obs_err = rsp_err;
      end else begin
        if (io_lsu_reqValid) begin
          if (wait_cnt == v.dly) begin
            if (obs_nb < 2) begin
              obs_addr[obs_nb] = io_lsu_addr; obs_size[obs_nb] = io_lsu_size;
              obs_wen[obs_nb] = io_lsu_wen; obs_mask[obs_nb] = io_lsu_wmask;
              obs_wdata[obs_nb] = io_lsu_wdata;
            end
            io_lsu_rdata = v.tbl ? ((obs_nb == 0) ? v.rd0 : v.rd1) : mem_word(io_lsu_addr);
            io_lsu_respValid = 1'b1;
            obs_nb++;
            wait_cnt = 0;
          end else begin
            wait_cnt++;
          end
        end
        @(negedge clk);
        io_lsu_respValid = 1'b0;
      end
    end
  endtask

  task automatic check_txn(input vec_t v, input string tag);
    logic [31:0] ea, ew;
    logic [3:0] em;
    chk({tag, ".done"}, 32'(obs_got), 32'd1);
    chk({tag, ".nbeats"}, obs_nb, v.nb);
    if (obs_got && obs_nb == v.nb) begin
      for (int k = 0; k < v.nb && k < 2; k++) begin
        ea = (k == 0) ? v.a0 : {v.a[31:2], 2'b00} + 32'd4;
        em = (k == 0) ? v.m0 : v.m1;
        ew = (k == 0) ? v.w0 : v.w1;
        chk($sformatf("%s.addr%0d", tag, k), obs_addr[k], ea);
        chk($sformatf("%s.size%0d", tag, k), 32'(obs_size[k]), (k == 0) ? 32'(v.sz0) : 32'd2);
        chk($sformatf("%s.wen%0d", tag, k), 32'(obs_wen[k]), 32'(v.w));
        chk($sformatf("%s.wmask%0d", tag, k), 32'(obs_mask[k]), 32'(em));
        if (v.w) chk($sformatf("%s.wdata%0d", tag, k), mskd(obs_wdata[k], em), mskd(ew, em));
      end
      chk({tag, ".rdata"}, obs_rdata, v.rdata);
      chk({tag, ".err"}, 32'(obs_err), 32'(v.err));
      chk({tag, ".latency"}, obs_lat, v.err ? 1 : v.nb * (v.dly + 1) + 1);
    end
    @(negedge clk);
    chk({tag, ".rsp_pulse"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".ready_after"}, 32'(req_ready), 32'd1);
  endtask

  vec_t tbl[$];
  vec_t rv;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Table rows: a w sz u wd rd0 rd1 dly | nb a0 sz0 m0 w0 m1 w1 rdata err
    tbl.push_back(mk(32'h80000008, 0, 2, 0, 0, 32'hDEADBEEF, 0, 2, 1, 32'h80000008, 2, 4'hF, 0, 0, 0, 32'hDEADBEEF, 0));
    tbl.push_back(mk(32'h80000003, 0, 0, 0, 0, 32'h80112233, 0, 0, 1, 32'h80000003, 0, 4'h8, 0, 0, 0, 32'hFFFFFF80, 0));
    tbl.push_back(mk(32'h80000003, 0, 0, 1, 0, 32'h80112233, 0, 1, 1, 32'h80000003, 0, 4'h8, 0, 0, 0, 32'h00000080, 0));
    tbl.push_back(mk(32'h80000002, 1, 1, 0, 32'h1234, 0, 0, 0, 1, 32'h80000002, 1, 4'hC, 32'h12340000, 0, 0, 0, 0));
    tbl.push_back(mk(32'h80000002, 0, 1, 0, 0, 32'h80011234, 0, 0, 1, 32'h80000002, 1, 4'hC, 0, 0, 0, 32'hFFFF8001, 0));
    tbl.push_back(mk(32'h80000004, 0, 3, 0, 0, 32'h12345678, 0, 0, 1, 32'h80000004, 2, 4'hF, 0, 0, 0, 32'h12345678, 0));
    tbl.push_back(mk(32'h80000001, 0, 0, 0, 0, 32'h00007F00, 0, 0, 1, 32'h80000001, 0, 4'h2, 0, 0, 0, 32'h0000007F, 0));
    tbl.push_back(mk(32'h80000001, 1, 0, 0, 32'hFFFFFFAB, 0, 0, 1, 1, 32'h80000001, 0, 4'h2, 32'h0000AB00, 0, 0, 0, 0));
`ifdef LSU_SPLIT_MISALIGNED_EN
    tbl.push_back(mk(32'h80000001, 0, 2, 0, 0, 32'h44332211, 32'h88776655, 0, 2, 32'h80000000, 2, 4'hE, 0, 4'h1, 0, 32'h55443322, 0));
    tbl.push_back(mk(32'h80000003, 1, 2, 0, 32'hAABBCCDD, 0, 0, 1, 2, 32'h80000000, 2, 4'h8, 32'hDD000000, 4'h7, 32'h00AABBCC, 0, 0));
    tbl.push_back(mk(32'h80000003, 0, 1, 1, 0, 32'hAB000000, 32'h000000CD, 2, 2, 32'h80000000, 2, 4'h8, 0, 4'h1, 0, 32'h0000CDAB, 0));
`else
    tbl.push_back(mk(32'h80000001, 0, 2, 0, 0, 32'h44332211, 32'h88776655, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(32'h80000003, 1, 2, 0, 32'hAABBCCDD, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(32'h80000003, 0, 1, 1, 0, 32'hAB000000, 32'h000000CD, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1));
`endif

    repeat (3) @(negedge clk);
    chk("reset.req_ready", 32'(req_ready), 32'd1);
    chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset.rsp_rdata", rsp_rdata, 32'd0);
    chk("reset.rsp_err", 32'(rsp_err), 32'd0);
    chk("reset.reqValid", 32'(io_lsu_reqValid), 32'd0);
    chk("reset.bus", {io_lsu_addr[27:0], io_lsu_wmask}, 32'd0);
    chk("reset.bus2", io_lsu_wdata | 32'({io_lsu_size, io_lsu_wen}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      run_txn(tbl[i]);
      check_txn(tbl[i], $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 150; i++) begin
      rv = model(32'h80000000 + $urandom_range(0, 63), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 2));
      run_txn(rv);
      check_txn(rv, $sformatf("rand%0d", i));
    end

    // Reset while a beat is outstanding; its late response must be dropped.
    req_valid = 1'b1; req_addr = EN ? 32'h80000001 : 32'h80000000;
    req_wen = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
`ifdef LSU_SPLIT_MISALIGNED_EN
    io_lsu_respValid = 1'b1; io_lsu_rdata = 32'h11111111;
    @(negedge clk);
    io_lsu_respValid = 1'b0;
    chk("rst_mid.beat1_addr", io_lsu_addr, 32'h80000004);
`endif
    chk("rst_mid.reqValid_before", 32'(io_lsu_reqValid), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid.reqValid", 32'(io_lsu_reqValid), 32'd0);
    chk("rst_mid.req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    io_lsu_respValid = 1'b1; io_lsu_rdata = 32'h22222222;
    @(negedge clk);
    io_lsu_respValid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_mid.no_rsp%0d", k), 32'(rsp_valid), 32'd0);
      @(negedge clk);
    end
    chk("rst_mid.idle_bus", 32'(io_lsu_reqValid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
